matriz_leds_scan: RTL and testbench
===================================

# matriz_leds_scan

Parametrised successor to the game's LED-matrix controller. It holds a ROWS×COLS board of toggle bits and flips programmable cell regions on debounced button *presses* (edges, not levels). It scans the active rows with a programmable dwell and anti-ghost blanking gap, and reports level completion and a move count to the game control unit. It sits between the synchronised button inputs and the physical matrix row/column drivers.

## Interface
Parameters:
- ROWS, 8: matrix rows (2..16).
- COLS, 8: matrix columns (2..16).
- NBTN, 8: number of buttons (1..16).
- DWELL, 1000: clock cycles each row is driven (≥1).
- BLANK, 4: clock cycles with all rows/columns off between rows (≥0; 0 means no gap).
- REGION_MAP, NBTN·ROWS·COLS bits: bit (b·ROWS·COLS + r·COLS + c) = 1 means button b toggles cell (r,c).
  - Default: button b toggles every cell of row b mod ROWS.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-high.
- botoes  in  NBTN  raw button levels, asynchronous to clk.
- nivel  in  3  current level from the control unit.
- linhas  out  ROWS  one-hot active-high row select; 0 during blanking.
- colunas  out  COLS  column data for the driven row; 0 during blanking.
- nivel_concluido  out  1  registered: every cell of every active row is 1.
- vitoria_pulse  out  1  one-cycle pulse on the 0→1 transition of nivel_concluido.
- jogadas  out  16  count of accepted presses, saturating at 16'hFFFF.

## Operation
- **Active rows:** A = min(2·nivel+1, ROWS). Only rows 0..A-1 are scanned and checked.
- **Button path:**
  - 2-FF synchroniser per button, then a third register for edge detection.
  - A press is s2 & ~s3. Holding a button gives exactly one press.
- **Toggle:** on a press cycle, each cell flips iff an odd number of pressed buttons map to it. Simultaneous presses therefore XOR.
- **jogadas:** +1 per cycle in which ≥1 press occurs, not +1 per button. Saturates at 16'hFFFF.
- **Scan FSM:** states DRIVE and GAP.
  - DRIVE: drive the current row for DWELL cycles, then enter GAP (or go straight to the next row if BLANK=0).
  - GAP: lasts BLANK cycles, then advance to the next row.
  - Row index wraps from A-1 to 0.
  - In DRIVE: linhas = 1<<row and colunas = board[row], reflecting live board contents.
- **Level change:** when nivel differs from its registered copy, on that edge:
  - board cleared to 0;
  - row set to 0, FSM to DRIVE, dwell counter to 0;
  - jogadas cleared.
  - Presses in the same cycle are discarded; the clear wins.
- **Completion:** nivel_concluido is registered from the board state. It drops when any active cell returns to 0.
- **Reset (any time, including mid-scan or mid-press):** on the next edge:
  - board = 0, jogadas = 0;
  - synchroniser and edge registers = 0;
  - row = 0, FSM = DRIVE, counter = 0.
  - A button held through reset registers one press once the synchroniser fills.

## Timing
- Reset values: linhas = 0, colunas = 0, nivel_concluido = 0, vitoria_pulse = 0, jogadas = 0.
  - First cycle after reset releases: linhas = 1, colunas = board[0] = 0.
- Button path, with a button first sampled high at edge N:
  - s1 = 1 after N, s2 = 1 after N+1;
  - board bit flips and jogadas increments at edge N+2;
  - nivel_concluido updates at N+3, vitoria_pulse at N+4.
- Rows and columns are registered outputs. One full frame is A·(DWELL+BLANK) cycles.
- If nivel changes while a row is driven, outputs return to row 0 on the next edge. No partial dwell is carried over.

## Test plan
- **Reset state:** assert rst for 3 cycles mid-scan → next cycle linhas = 0, colunas = 0, jogadas = 0. After release, linhas = 8'h01.
- **Edge-only toggle:** defaults, nivel = 0, hold botoes[0] high for 50 cycles → board row 0 = 8'hFF exactly once, jogadas = 1. nivel_concluido = 1 at N+3, vitoria_pulse high for one cycle at N+4.
- **Overlapping presses:** REGION_MAP maps buttons 0 and 1 both to cell (0,0); press both in the same cycle → cell (0,0) unchanged, jogadas = 1.
- **Scan and blanking:** DWELL = 3, BLANK = 2, nivel = 1 (A = 3) → linhas sequence 01,01,01,00,00,02,02,02,00,00,04,04,04,00,00,01…; colunas = 0 in every 00 cycle.
- **Level change clears:**
  - Set row 0 = FF at nivel = 0, then switch to nivel = 2 in the same cycle as a press → board all 0, jogadas = 0, press ignored, scan restarts at linhas = 01.
  - Ending at nivel = 4 (A = 8): the scan wraps after row 7.
- **Saturation:** preload via 65 540 presses → jogadas holds 16'hFFFF.

Source files
------------

// File: rtl/matriz_leds_scan.sv
// matriz_leds_scan: ROWSxCOLS toggle-bit board for the LED puzzle game.
// Latency: a button sampled high at edge N flips the board and bumps jogadas at
// edge N+2. nivel_concluido follows at N+3 and vitoria_pulse at N+4. Row and
// column outputs are registered one cycle behind the scan state.
// Backpressure: none; buttons are sampled every cycle and the scan free-runs.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   botoes[NBTN]     raw button levels (asynchronous to clk)
//   nivel[3]         current level; any change clears the board and restarts the scan
//   linhas[ROWS]     one-hot row drive, 0 while blanking
//   colunas[COLS]    column data of the driven row, 0 while blanking
//   nivel_concluido  every cell of every active row is lit
//   vitoria_pulse    one-cycle pulse when nivel_concluido rises
//   jogadas[16]      accepted press cycles, saturating at 16'hFFFF

package matriz_leds_scan_pkg;

    // Default region map: button b toggles the whole of row (b mod rows).
    // Sized for the largest legal board (16 buttons x 16 x 16 cells).
    function automatic logic [4095:0] default_region_map(input int nbtn,
                                                         input int rows,
                                                         input int cols);
        logic [4095:0] m;
        m = '0;
        for (int b = 0; b < nbtn; b++) begin
            for (int c = 0; c < cols; c++) begin
                m[b*rows*cols + (b % rows)*cols + c] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

module matriz_leds_scan #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int NBTN  = 8,
    parameter int DWELL = 1000,
    parameter int BLANK = 4,
    // Bit (b*ROWS*COLS + r*COLS + c) set: button b toggles cell (r,c).
    parameter REGION_MAP = matriz_leds_scan_pkg::default_region_map(NBTN, ROWS, COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] botoes,
    input  logic [2:0]      nivel,
    output logic [ROWS-1:0] linhas,
    output logic [COLS-1:0] colunas,
    output logic            nivel_concluido,
    output logic            vitoria_pulse,
    output logic [15:0]     jogadas
);

    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(ROWS);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = (BLANK > 0) ? CW'(BLANK - 1) : '0;

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_GAP   = 1'b1
    } scan_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NBTN-1:0]            s1_q, s1_d;
    logic [NBTN-1:0]            s2_q, s2_d;
    logic [NBTN-1:0]            s3_q, s3_d;
    logic [2:0]                 nivel_q, nivel_d;
    logic [ROWS-1:0][COLS-1:0]  board_q, board_d;
    logic [15:0]                jogadas_q, jogadas_d;
    scan_state_t                state_q, state_d;
    logic [RW-1:0]              row_q, row_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [ROWS-1:0]            linhas_q, linhas_d;
    logic [COLS-1:0]            colunas_q, colunas_d;
    logic                       concl_q, concl_d;
    logic                       concl_dly_q, concl_dly_d;
    logic                       vitoria_q, vitoria_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [NBTN-1:0]            press;
    logic                       lvl_chg;
    logic [4:0]                 act_raw;
    logic [4:0]                 act_rows;
    logic [4:0]                 last_row;
    logic [RW-1:0]              next_row;
    logic [ROWS-1:0][COLS-1:0]  toggle;
    logic                       all_on;

    // Button path: two synchroniser stages, a third stage for rising-edge
    // detection. Level tracking against the registered nivel copy.
    always_comb begin
        s1_d    = botoes;
        s2_d    = s1_q;
        s3_d    = s2_q;
        nivel_d = nivel;
        press   = s2_q & ~s3_q;
        lvl_chg = (nivel != nivel_q);
    end

    // Active rows A = min(2*nivel+1, ROWS), taken from the registered level so
    // that scan and completion agree with the board that was cleared for it.
    always_comb begin
        act_raw  = {1'b0, nivel_q, 1'b1};
        act_rows = (act_raw > 5'(ROWS)) ? 5'(ROWS) : act_raw;
        last_row = act_rows - 5'd1;
        next_row = (5'(row_q) >= last_row) ? '0 : row_q + 1'b1;
    end

    // Each cell flips when an odd number of this cycle's presses cover it,
    // so simultaneous presses on overlapping regions cancel out.
    always_comb begin
        toggle = '0;
        for (int b = 0; b < NBTN; b++) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    toggle[r][c] = toggle[r][c] ^
                                   (press[b] & REGION_MAP[b*ROWS*COLS + r*COLS + c]);
                end
            end
        end
    end

    // Board and move counter. A level change wins over any press landing on
    // the same edge: the board and count are cleared and the press is lost.
    always_comb begin
        board_d   = board_q ^ toggle;
        jogadas_d = jogadas_q;
        if (lvl_chg) begin
            board_d   = '0;
            jogadas_d = '0;
        end else if ((|press) && (jogadas_q != 16'hFFFF)) begin
            jogadas_d = jogadas_q + 16'd1;
        end
    end

    // Completion flag and its rising-edge pulse.
    always_comb begin
        all_on = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            if ((5'(r) < act_rows) && !(&board_q[r])) begin
                all_on = 1'b0;
            end
        end
        concl_d     = all_on;
        concl_dly_d = concl_q;
        vitoria_d   = concl_q & ~concl_dly_q;
    end

    // Scan sequencer: DWELL cycles on a row, then BLANK dark cycles (skipped
    // entirely when BLANK is 0), then the next active row.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            ST_DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (BLANK == 0) begin
                        row_d = next_row;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DRIVE;
                    row_d   = next_row;
                end
            end
            default: begin
                state_d = ST_DRIVE;
                row_d   = '0;
                cnt_d   = '0;
            end
        endcase
        if (lvl_chg) begin
            state_d = ST_DRIVE;
            row_d   = '0;
            cnt_d   = '0;
        end
    end

    // Outputs are registered from the current scan state, so each scan state
    // appears on the pins exactly one cycle after it is entered. This keeps
    // every dwell and gap at its full length, including the first row after
    // reset or a level change.
    always_comb begin
        linhas_d  = '0;
        colunas_d = '0;
        if (state_q == ST_DRIVE) begin
            linhas_d  = {{(ROWS-1){1'b0}}, 1'b1} << row_q;
            colunas_d = board_q[row_q];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            // Track the live level during reset so leaving reset is not
            // mistaken for a level change.
            nivel_q     <= nivel;
            board_q     <= '0;
            jogadas_q   <= '0;
            state_q     <= ST_DRIVE;
            row_q       <= '0;
            cnt_q       <= '0;
            linhas_q    <= '0;
            colunas_q   <= '0;
            concl_q     <= 1'b0;
            concl_dly_q <= 1'b0;
            vitoria_q   <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            nivel_q     <= nivel_d;
            board_q     <= board_d;
            jogadas_q   <= jogadas_d;
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            linhas_q    <= linhas_d;
            colunas_q   <= colunas_d;
            concl_q     <= concl_d;
            concl_dly_q <= concl_dly_d;
            vitoria_q   <= vitoria_d;
        end
    end

    assign linhas          = linhas_q;
    assign colunas         = colunas_q;
    assign nivel_concluido = concl_q;
    assign vitoria_pulse   = vitoria_q;
    assign jogadas         = jogadas_q;

endmodule

// File: tb/tb_matriz_leds_scan.sv
// Bench for matriz_leds_scan: two instances, an 8x8 board with the default
// region map (short dwell/blank) and a 2x2 board with overlapping regions.
// Table-driven reset/scan vectors plus directed multi-cycle sequences.

module tb_matriz_leds_scan;

    logic        clk = 1'b0;
    logic        rst;

    logic [7:0]  botoes_a;
    logic [2:0]  nivel_a;
    logic [7:0]  linhas_a;
    logic [7:0]  colunas_a;
    logic        concl_a;
    logic        vit_a;
    logic [15:0] jog_a;

    logic [1:0]  botoes_b;
    logic [2:0]  nivel_b;
    logic [1:0]  linhas_b;
    logic [1:0]  colunas_b;
    logic        concl_b;
    logic        vit_b;
    logic [15:0] jog_b;

    int total = 0;
    int bad   = 0;

    matriz_leds_scan #(
        .ROWS(8), .COLS(8), .NBTN(8), .DWELL(3), .BLANK(2)
    ) dut_a (
        .clk(clk), .rst(rst), .botoes(botoes_a), .nivel(nivel_a),
        .linhas(linhas_a), .colunas(colunas_a), .nivel_concluido(concl_a),
        .vitoria_pulse(vit_a), .jogadas(jog_a)
    );

    // Button 0 -> cells (0,0),(0,1); button 1 -> cells (0,0),(1,0).
    matriz_leds_scan #(
        .ROWS(2), .COLS(2), .NBTN(2), .DWELL(1), .BLANK(0), .REGION_MAP(8'h53)
    ) dut_b (
        .clk(clk), .rst(rst), .botoes(botoes_b), .nivel(nivel_b),
        .linhas(linhas_b), .colunas(colunas_b), .nivel_concluido(concl_b),
        .vitoria_pulse(vit_b), .jogadas(jog_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic row_a(input int r, output logic [7:0] cols);
        bit found;
        logic [7:0] want;
        found = 1'b0;
        want  = 8'h01 << r;
        cols  = 'x;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (linhas_a == want) begin
                found = 1'b1;
                cols  = colunas_a;
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL row_a_timeout: row %0d never driven", r);
        end
    endtask

    task automatic row_b(input int r, output logic [1:0] cols);
        bit found;
        logic [1:0] want;
        found = 1'b0;
        want  = 2'b01 << r;
        cols  = 'x;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (linhas_b == want) begin
                found = 1'b1;
                cols  = colunas_b;
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL row_b_timeout: row %0d never driven", r);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  nivel;
        logic [7:0]  linhas;
        logic [7:0]  colunas;
        logic [15:0] jog;
        logic        concl;
    } vec_t;

    initial begin
        vec_t       vecs[$];
        logic [7:0] seq [21];
        logic [7:0] cols8;
        logic [1:0] cols2;
        logic [7:0] prev;
        int         k;

        rst      = 1'b1;
        botoes_a = '0;
        nivel_a  = 3'd1;
        botoes_b = '0;
        nivel_b  = 3'd1;

        // ---- Reset state and scan/blanking: DWELL=3, BLANK=2, A=3 ----
        seq = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00,
                8'h02, 8'h02, 8'h02, 8'h00, 8'h00,
                8'h04, 8'h04, 8'h04, 8'h00, 8'h00,
                8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02};
        for (int i = 0; i < 3; i++)
            vecs.push_back('{1'b1, 3'd1, 8'h00, 8'h00, 16'h0000, 1'b0});
        for (int i = 0; i < 21; i++)
            vecs.push_back('{1'b0, 3'd1, seq[i], 8'h00, 16'h0000, 1'b0});

        foreach (vecs[i]) begin
            rst     = vecs[i].rst;
            nivel_a = vecs[i].nivel;
            tick();
            chk($sformatf("vec%0d_linhas", i), linhas_a, vecs[i].linhas);
            chk($sformatf("vec%0d_colunas", i), colunas_a, vecs[i].colunas);
            chk($sformatf("vec%0d_jogadas", i), jog_a, vecs[i].jog);
            chk($sformatf("vec%0d_concl", i), concl_a, vecs[i].concl);
            chk($sformatf("vec%0d_vit", i), vit_a, 1'b0);
        end

        // ---- Edge-only toggle: nivel 0 (A=1), hold button 0 ----
        nivel_a = 3'd0;
        repeat (4) tick();
        botoes_a = 8'h01;
        tick();                                   // edge N
        chk("tog_jog_N", jog_a, 16'd0);
        tick();                                   // N+1
        chk("tog_jog_N1", jog_a, 16'd0);
        tick();                                   // N+2
        chk("tog_jog_N2", jog_a, 16'd1);
        chk("tog_concl_N2", concl_a, 1'b0);
        tick();                                   // N+3
        chk("tog_concl_N3", concl_a, 1'b1);
        chk("tog_vit_N3", vit_a, 1'b0);
        tick();                                   // N+4
        chk("tog_vit_N4", vit_a, 1'b1);
        tick();                                   // N+5
        chk("tog_vit_N5", vit_a, 1'b0);
        chk("tog_concl_N5", concl_a, 1'b1);
        repeat (45) tick();
        chk("tog_jog_held", jog_a, 16'd1);
        row_a(0, cols8);
        chk("tog_row0", cols8, 8'hFF);

        // ---- Reset mid-scan with button still held ----
        rst = 1'b1;
        tick();
        chk("mrst_linhas", linhas_a, 8'h00);
        chk("mrst_colunas", colunas_a, 8'h00);
        chk("mrst_jog", jog_a, 16'd0);
        chk("mrst_concl", concl_a, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("mrst_rel_linhas", linhas_a, 8'h01);
        chk("mrst_rel_colunas", colunas_a, 8'h00);
        chk("mrst_rel_jog", jog_a, 16'd0);
        tick();
        chk("mrst_rel_jog1", jog_a, 16'd0);
        tick();
        chk("mrst_held_press", jog_a, 16'd1);
        repeat (10) tick();
        chk("mrst_held_once", jog_a, 16'd1);
        row_a(0, cols8);
        chk("mrst_row0", cols8, 8'hFF);
        chk("mrst_concl_again", concl_a, 1'b1);

        // ---- Level change on the same edge as a press ----
        botoes_a = 8'h00;
        repeat (5) tick();
        botoes_a = 8'h02;                         // button 1 -> row 1
        tick();                                   // N
        tick();                                   // N+1
        nivel_a = 3'd2;
        tick();                                   // N+2: press and clear coincide
        chk("lvl_jog_cleared", jog_a, 16'd0);
        tick();
        chk("lvl_restart_linhas", linhas_a, 8'h01);
        chk("lvl_restart_colunas", colunas_a, 8'h00);
        botoes_a = 8'h00;
        row_a(1, cols8);
        chk("lvl_row1_ignored", cols8, 8'h00);
        row_a(0, cols8);
        chk("lvl_row0_cleared", cols8, 8'h00);
        chk("lvl_jog_stays", jog_a, 16'd0);
        chk("lvl_concl", concl_a, 1'b0);

        // ---- nivel 4 -> A=8, scan wraps after row 7 ----
        nivel_a = 3'd4;
        tick();
        prev = 8'h00;
        k    = 0;
        for (int i = 0; i < 80 && k < 9; i++) begin
            tick();
            if (linhas_a != 8'h00 && linhas_a != prev) begin
                chk($sformatf("wrap_row%0d", k), linhas_a, 8'h01 << (k % 8));
                prev = linhas_a;
                k++;
            end
        end
        if (k < 9) begin
            total++;
            bad++;
            $display("FAIL wrap_timeout: saw %0d rows, required 9", k);
        end

        // ---- Overlapping regions on the 2x2 instance ----
        botoes_b = 2'b11;
        repeat (6) tick();
        botoes_b = 2'b00;
        repeat (4) tick();
        chk("ovl_jog_once", jog_b, 16'd1);
        row_b(0, cols2);
        chk("ovl_row0", cols2, 2'b10);
        row_b(1, cols2);
        chk("ovl_row1", cols2, 2'b01);
        chk("ovl_concl", concl_b, 1'b0);
        botoes_b = 2'b10;
        repeat (6) tick();
        botoes_b = 2'b00;
        repeat (4) tick();
        chk("ovl_jog_two", jog_b, 16'd2);
        row_b(0, cols2);
        chk("ovl_b1_row0", cols2, 2'b11);
        row_b(1, cols2);
        chk("ovl_b1_row1", cols2, 2'b00);

        // ---- jogadas counting and saturation (one press per cycle) ----
        for (int i = 0; i < 1000; i++) begin
            botoes_a = (i % 2 == 0) ? 8'h01 : 8'h02;
            tick();
        end
        botoes_a = 8'h00;
        repeat (4) tick();
        chk("cnt_1000", jog_a, 16'd1000);
        for (int i = 0; i < 64600; i++) begin
            botoes_a = (i % 2 == 0) ? 8'h01 : 8'h02;
            tick();
        end
        botoes_a = 8'h00;
        repeat (4) tick();
        chk("cnt_saturated", jog_a, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
